// File: rtl/mmio_uart_tx_pkg.sv
// Package for the memory-mapped UART transmitter.
// Holds the transmitter FSM state type, the register offsets inside the UART
// window, the STATUS bit positions and a helper that packs the FIFO count
// into the 4-bit STATUS field.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // The STATUS count field is only 4 bits wide; deeper FIFOs saturate at 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Store/load bus between the core's data-memory port and the UART window.
//   cs         : UART window selected by the top-level decoder
//   we         : store strobe
//   byteEnable : store byte lanes
//   a          : byte offset within the window
//   wd         : store data
//   rd         : load data returned by the UART
// master = core side, slave = UART side.
interface mmio_uart_tx_if;
    logic        cs;
    logic        we;
    logic [3:0]  byteEnable;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output cs, we, byteEnable, a, wd, input rd);
    modport slave  (input cs, we, byteEnable, a, wd, output rd);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write request (accepted when not full, or when a pop
//                  happens in the same cycle)
//   i_pop        : read request (ignored while empty)
//   i_data       : write data
//   o_data       : head entry
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_count      : number of entries held
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still lands when the head is leaving.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory store bus.
// Bytes stored to TXDATA are queued in a FIFO and shifted out LSB first;
// STATUS reports full/empty/busy/overflow and the queued byte count.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus            : store/load bus (slave side)
//   o_tx           : serial line, idle high, registered
//   o_irq          : high while the FIFO is empty and the shifter is idle
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mmio_uart_tx_if.slave bus,
    output logic          o_tx,
    output logic          o_irq
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;

    uart_state_t w_next_state;
    logic [BW-1:0] w_next_baud;
    logic [2:0]    w_next_bit;
    logic [7:0]    w_next_shift;
    logic          w_next_tx;

    logic          w_tick;
    logic          w_push;
    logic          w_clr;
    logic          w_drop;
    logic          w_pop_req;
    logic [7:0]    w_fifo_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_unused;

    // Store decode: only lane 0 carries the byte and the clear bit.
    assign w_push = bus.cs & bus.we & (bus.a[3:2] == UART_TXDATA[3:2]) & bus.byteEnable[0];
    assign w_clr  = bus.cs & bus.we & (bus.a[3:2] == UART_STATUS[3:2]) & bus.byteEnable[0]
                  & bus.wd[ST_OVF];

    assign w_unused = ^{bus.wd[31:8], bus.byteEnable[3:1], bus.a[1:0]};

    // The counter sits at 0 in IDLE, so every bit period after a pop is a
    // full CLK_DIV cycles.
    assign w_tick = (r_state != IDLE) && (r_baud == BW'(CLK_DIV - 1));

    // The FIFO ignores the pop while empty, which lets IDLE request every cycle.
    assign w_pop_req = (r_state == IDLE) || ((r_state == STOP) && w_tick);

    // Full implies non-empty, so the pop request alone decides whether the
    // head leaves this cycle.
    assign w_drop = w_push & w_full & ~w_pop_req;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop_req),
        .i_data  (bus.wd[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_baud  <= w_next_baud;
            r_bit   <= w_next_bit;
            r_shift <= w_next_shift;
            r_tx    <= w_next_tx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_bit   = r_bit;
        w_next_shift = r_shift;
        if (r_state == IDLE || w_tick) w_next_baud = '0;
        else                           w_next_baud = r_baud + 1'b1;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next_state = START;
                    w_next_shift = w_fifo_data;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = DATA;
                    w_next_bit   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_next_shift = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_next_state = STOP;
                    else               w_next_bit   = r_bit + 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        w_next_state = START;
                        w_next_shift = w_fifo_data;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Line level is computed from the next state so it can be registered.
        case (w_next_state)
            START:   w_next_tx = 1'b0;
            DATA:    w_next_tx = w_next_shift[0];
            default: w_next_tx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)     r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
        else if (w_clr)  r_ovf <= 1'b0;
    end

    always_comb begin
        bus.rd = '0;
        if (bus.a[3:2] == UART_STATUS[3:2]) begin
            bus.rd[ST_FULL]             = w_full;
            bus.rd[ST_EMPTY]            = w_empty;
            bus.rd[ST_BUSY]             = (r_state != IDLE);
            bus.rd[ST_OVF]              = r_ovf;
            bus.rd[ST_CNT_LSB +: 4]     = sat_count4(32'(w_count));
        end
    end

    assign o_tx  = r_tx;
    assign o_irq = w_empty & (r_state == IDLE);
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    localparam int DIV = 4;
    localparam int D   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, irq;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(D)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave),
        .o_tx    (tx),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        int         t;
    } frame_t;

    // Reference model: pending bytes, expected frames with their start edge,
    // shifter busy flag, edge index at which the running frame ends.
    logic [7:0] mq[$];
    frame_t     expq[$];
    bit         idle_m = 1'b1;
    bit         ovf_m  = 1'b0;
    int         next_pop = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = mq.size();
        s = '0;
        s[0] = (n == D);
        s[1] = (n == 0);
        s[2] = !idle_m;
        s[3] = ovf_m;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    // One bus cycle: drive at the falling edge, check the combinational load
    // data and irq, then advance the model across the coming rising edge.
    task automatic step(input bit cs, input bit we, input logic [3:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        int e;
        bit pop;
        frame_t f;
        @(negedge clk);
        bus.cs = cs; bus.we = we; bus.a = a; bus.byteEnable = be; bus.wd = wd;
        #1;
        chk("rd", bus.rd, (a[3:2] == 2'd1) ? model_status() : 32'h0);
        chk("irq", 32'(irq), 32'((mq.size() == 0) && idle_m));
        e = cyc;
        pop = 1'b0;
        if (!idle_m && e == next_pop) begin
            if (mq.size() > 0) pop = 1'b1;
            else               idle_m = 1'b1;
        end else if (idle_m && mq.size() > 0) begin
            pop = 1'b1;
        end
        if (pop) begin
            f.d = mq.pop_front();
            f.t = e;
            expq.push_back(f);
            idle_m = 1'b0;
            next_pop = e + 10 * DIV;
        end
        if (cs && we && a[3:2] == 2'd0 && be[0]) begin
            if (mq.size() < D) mq.push_back(wd[7:0]);
            else               ovf_m = 1'b1;
        end
        if (cs && we && a[3:2] == 2'd1 && be[0] && wd[3]) ovf_m = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h4, 4'h0, 32'h0);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, 1'b1, 4'h0, 4'b0001, {24'hABCDEF, d});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((!idle_m || mq.size() != 0) && n < 3000) begin
            idle_n(1);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: model still busy after %0d cycles, required idle", n);
        end
        idle_n(10 * DIV + 5);
    endtask

    task automatic rnd_op(input int pct);
        int r;
        logic [31:0] w;
        logic [3:0] be;
        r = $urandom_range(0, 99);
        w = $urandom;
        be = 4'($urandom);
        if (r < pct)
            step(1'b1, 1'b1, 4'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? be : (be | 4'h1), w);
        else if (r < pct + 2)
            step(1'b1, 1'b1, 4'h4, be, w);
        else if (r < pct + 4)
            step(1'b0, 1'b1, 4'($urandom), 4'hF, w);
        else
            step(1'b1, 1'b0, 4'($urandom), be, w);
    endtask

    // Monitor: decodes each frame from the line and compares it with the
    // oldest expected frame.
    initial begin : monitor
        frame_t f;
        logic [9:0] lv;
        logic [7:0] got;
        int st, bad;
        bit have;
        forever begin
            @(posedge clk); #1;
            if (mon_en && tx === 1'b0) begin
                st = cyc - 1;
                have = (expq.size() != 0);
                if (have) begin
                    f = expq.pop_front();
                    chk("start_cycle", 32'(st), 32'(f.t));
                end else begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: start at cycle %0d, required no frame", st);
                    f.d = 8'h00; f.t = st;
                end
                lv = {1'b1, f.d, 1'b0};
                bad = 0;
                got = '0;
                for (int s = 1; s < 10 * DIV; s++) begin
                    @(posedge clk); #1;
                    if (tx !== lv[s / DIV]) bad++;
                    if ((s % DIV) == DIV / 2 && s / DIV >= 1 && s / DIV <= 8) got[s / DIV - 1] = tx;
                end
                if (have) begin
                    chk("frame_data", 32'(got), 32'(f.d));
                    chk("frame_shape", 32'(bad), 32'h0);
                end
            end
        end
    end

    initial begin : stim
        bus.cs = 1'b0; bus.we = 1'b0; bus.a = 4'h4; bus.byteEnable = 4'h0; bus.wd = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'h1);
        chk("reset_status", bus.rd, 32'h2);
        chk("reset_irq", 32'(irq), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Start a frame, then reset in the middle of the data bits.
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.a = 4'h0; bus.byteEnable = 4'b0001; bus.wd = 32'hA5;
        @(negedge clk);
        bus.we = 1'b0; bus.a = 4'h4;
        repeat (10) @(negedge clk);
        #1;
        chk("pre_reset_tx", 32'(tx), 32'h0);
        chk("pre_reset_busy", 32'(bus.rd[2]), 32'h1);
        #2 reset = 1'b1;
        #1 chk("async_reset_tx", 32'(tx), 32'h1);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_reset_status", bus.rd, 32'h2);
        chk("mid_reset_irq", 32'(irq), 32'h1);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single byte.
        push(8'hA5);
        idle_n(45);

        // Lane filter: byte lane 1 only, nothing must go out.
        step(1'b1, 1'b1, 4'h0, 4'b0010, 32'h55);
        idle_n(45);
        chk("lane_filter_status", bus.rd, 32'h2);

        // Back-to-back frames.
        push(8'h01); push(8'h02); push(8'h03);
        idle_n(130);

        // Overflow: six consecutive pushes.
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        idle_n(1);
        chk("ovf_status", bus.rd, 32'h4D);
        step(1'b1, 1'b1, 4'h4, 4'b0001, 32'h8);
        idle_n(1);
        chk("ovf_clear", 32'(bus.rd[3]), 32'h0);
        drain();

        // Full FIFO with a push landing on the stop-bit pop edge.
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        for (int n = 0; n < 100 && (cyc + 1) != next_pop; n++) idle_n(1);
        push(8'hC3);
        idle_n(1);
        chk("full_pop_push_status", bus.rd, 32'h45);
        drain();

        // Randomized traffic: sparse, then bursty enough to overflow.
        for (int i = 0; i < 1500; i++) rnd_op(3);
        for (int i = 0; i < 1000; i++) rnd_op(12);
        drain();
        chk("frames_outstanding", 32'(expq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
